// File: rtl/timer_a_tick_counter_pkg.sv
// Shared Timer_A definitions: mode, source-select and input-divider encodings,
// plus a helper that turns an ID code into the stage-1 divider terminal count.
package timer_a_tick_counter_pkg;

    typedef enum logic [1:0] {
        MC_STOP   = 2'b00,
        MC_UP     = 2'b01,
        MC_CONT   = 2'b10,
        MC_UPDOWN = 2'b11
    } mc_e;

    typedef enum logic [1:0] {
        TASSEL_TACLK = 2'b00,
        TASSEL_ACLK  = 2'b01,
        TASSEL_SMCLK = 2'b10,
        TASSEL_INCLK = 2'b11
    } tassel_e;

    typedef enum logic [1:0] {
        ID_DIV1 = 2'b00,
        ID_DIV2 = 2'b01,
        ID_DIV4 = 2'b10,
        ID_DIV8 = 2'b11
    } id_e;

    // Terminal count of the stage-1 divider, i.e. 2^ID - 1.
    function automatic logic [2:0] id_limit(input logic [1:0] id);
        logic [2:0] lim;
        unique case (id)
            ID_DIV1: lim = 3'd0;
            ID_DIV2: lim = 3'd1;
            ID_DIV4: lim = 3'd3;
            default: lim = 3'd7;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/timer_a_prescaler.sv
// Timer_A source path: synchronises all four clock sources to the system
// clock, selects one, detects its rising edges and divides them by
// 2^ID * (IDEX+1).
//   clk_i        system clock (MCLK)
//   rst_ni       asynchronous active-low reset
//   src_i[3:0]   raw sources {INCLK, SMCLK, ACLK, TACLK}
//   tassel_i     source select
//   id_i         stage-1 divide code
//   idex_i       stage-2 divide minus one
//   clr_i        level clear of both divider stages
//   tick_o       one-cycle pulse per divided timer clock
module timer_a_prescaler
    import timer_a_tick_counter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] src_i,
    input  logic [1:0] tassel_i,
    input  logic [1:0] id_i,
    input  logic [2:0] idex_i,
    input  logic       clr_i,
    output logic       tick_o
);

    logic [SYNC_STAGES-1:0] sync_q [4];
    logic [3:0]             prev_q;
    logic [3:0]             sync_last;
    logic [2:0]             div1_q, div1_d;
    logic [2:0]             div2_q, div2_d;
    logic                   src_tick;
    logic                   div1_wrap;
    logic                   div2_wrap;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 4; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
            div1_q <= '0;
            div2_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], src_i[i]};
            end
            prev_q <= sync_last;
            div1_q <= div1_d;
            div2_q <= div2_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sync_last[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Edge history is kept per source, so switching TASSEL onto a source that
    // is already high does not look like a rising edge.
    assign src_tick  = sync_last[tassel_i] & ~prev_q[tassel_i];

    // >= so a shrunken limit wraps at once instead of running past it.
    assign div1_wrap = (div1_q >= id_limit(id_i));
    assign div2_wrap = (div2_q >= idex_i);

    always_comb begin
        div1_d = div1_q;
        div2_d = div2_q;
        if (clr_i) begin
            div1_d = '0;
            div2_d = '0;
        end else if (src_tick) begin
            if (div1_wrap) begin
                div1_d = '0;
                div2_d = div2_wrap ? 3'd0 : div2_q + 3'd1;
            end else begin
                div1_d = div1_q + 3'd1;
            end
        end
    end

    assign tick_o = src_tick & div1_wrap & div2_wrap & ~clr_i;

endmodule

// File: rtl/timer_a_tick_counter.sv
// Timer_A clocking-and-count core: source selection and prescaling (in
// timer_a_prescaler) followed by the 16-bit TAR counter and its mode logic.
//   MCLK, reset            system clock, asynchronous active-low reset
//   TACLK/ACLK/SMCLK/INCLK timer sources selected by TASSEL
//   ID, IDEX               two-stage input divider
//   MC                     stop / up / continuous / up-down
//   TACLR                  level clear of TAR, dividers and direction
//   CCR0                   period limit for up and up/down modes
//   TAR_wr, TAR_wdata      direct load of TAR
//   TAR                    current count
//   TimerTick              one pulse per divided timer clock
//   TAIFGset               one pulse per overflow/period event
//   CountDown              high while counting down in up/down mode
module timer_a_tick_counter
    import timer_a_tick_counter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        MCLK,
    input  logic        reset,
    input  logic        TACLK,
    input  logic        ACLK,
    input  logic        SMCLK,
    input  logic        INCLK,
    input  logic [1:0]  TASSEL,
    input  logic [1:0]  ID,
    input  logic [2:0]  IDEX,
    input  logic [1:0]  MC,
    input  logic        TACLR,
    input  logic [15:0] CCR0,
    input  logic        TAR_wr,
    input  logic [15:0] TAR_wdata,
    output logic [15:0] TAR,
    output logic        TimerTick,
    output logic        TAIFGset,
    output logic        CountDown
);

    logic [15:0] tar_q, tar_d;
    logic        cd_q, cd_d;
    logic        flag_q, flag_d;
    logic        timer_tick;

    timer_a_prescaler #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_prescaler (
        .clk_i    (MCLK),
        .rst_ni   (reset),
        .src_i    ({INCLK, SMCLK, ACLK, TACLK}),
        .tassel_i (TASSEL),
        .id_i     (ID),
        .idex_i   (IDEX),
        .clr_i    (TACLR),
        .tick_o   (timer_tick)
    );

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            tar_q  <= '0;
            cd_q   <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            tar_q  <= tar_d;
            cd_q   <= cd_d;
            flag_q <= flag_d;
        end
    end

    always_comb begin
        tar_d  = tar_q;
        cd_d   = cd_q;
        flag_d = 1'b0;
        // Direction only has meaning in up/down mode.
        if (MC != MC_UPDOWN) begin
            cd_d = 1'b0;
        end
        if (TACLR) begin
            tar_d = '0;
            cd_d  = 1'b0;
        end else if (TAR_wr) begin
            tar_d = TAR_wdata;
        end else if (timer_tick) begin
            unique case (MC)
                MC_STOP: ;
                MC_UP: begin
                    if (CCR0 == 16'h0000) begin
                        tar_d = '0;
                    end else if (tar_q >= CCR0) begin
                        tar_d  = '0;
                        flag_d = 1'b1;
                    end else begin
                        tar_d = tar_q + 16'd1;
                    end
                end
                MC_CONT: begin
                    tar_d  = tar_q + 16'd1;
                    flag_d = (tar_q == 16'hFFFF);
                end
                default: begin
                    if (CCR0 != 16'h0000) begin
                        if (!cd_q) begin
                            if (tar_q >= CCR0) begin
                                cd_d  = 1'b1;
                                tar_d = tar_q - 16'd1;
                            end else begin
                                tar_d = tar_q + 16'd1;
                            end
                        end else if (tar_q == 16'h0001) begin
                            tar_d  = '0;
                            cd_d   = 1'b0;
                            flag_d = 1'b1;
                        end else if (tar_q == 16'h0000) begin
                            // Reached zero by a load while counting down.
                            cd_d  = 1'b0;
                            tar_d = 16'd1;
                        end else begin
                            tar_d = tar_q - 16'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign TAR       = tar_q;
    assign CountDown = cd_q;
    assign TAIFGset  = flag_q;
    assign TimerTick = timer_tick;

endmodule

// File: tb/tb_timer_a_tick_counter.sv
module tb_timer_a_tick_counter;

    logic        MCLK = 1'b0;
    logic        reset = 1'b0;
    logic        TACLK = 1'b0, ACLK = 1'b0, SMCLK = 1'b0, INCLK = 1'b0;
    logic [1:0]  TASSEL = 2'b10;
    logic [1:0]  ID = 2'b00;
    logic [2:0]  IDEX = 3'b000;
    logic [1:0]  MC = 2'b00;
    logic        TACLR = 1'b0;
    logic [15:0] CCR0 = 16'd0;
    logic        TAR_wr = 1'b0;
    logic [15:0] TAR_wdata = 16'd0;
    logic [15:0] TAR;
    logic        TimerTick, TAIFGset, CountDown;

    timer_a_tick_counter #(
        .SYNC_STAGES (2)
    ) dut (
        .MCLK      (MCLK),
        .reset     (reset),
        .TACLK     (TACLK),
        .ACLK      (ACLK),
        .SMCLK     (SMCLK),
        .INCLK     (INCLK),
        .TASSEL    (TASSEL),
        .ID        (ID),
        .IDEX      (IDEX),
        .MC        (MC),
        .TACLR     (TACLR),
        .CCR0      (CCR0),
        .TAR_wr    (TAR_wr),
        .TAR_wdata (TAR_wdata),
        .TAR       (TAR),
        .TimerTick (TimerTick),
        .TAIFGset  (TAIFGset),
        .CountDown (CountDown)
    );

    always #5 MCLK = ~MCLK;

    typedef struct packed {
        logic [15:0] tar;
        logic        flag;
        logic        cd;
    } exp_t;

    exp_t sb_q[$];
    bit   sb_en = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   tick_cnt = 0;
    int   spur = 0;
    logic tick_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full SMCLK period, long enough for the synchroniser and TAR update.
    task automatic pulse();
        @(posedge MCLK); #1 SMCLK = 1'b1;
        repeat (4) @(posedge MCLK);
        #1 SMCLK = 1'b0;
        repeat (4) @(posedge MCLK);
    endtask

    task automatic push(input logic [15:0] tar, input logic flag, input logic cd);
        exp_t e;
        e.tar  = tar;
        e.flag = flag;
        e.cd   = cd;
        sb_q.push_back(e);
    endtask

    task automatic clear_pulse();
        @(posedge MCLK); #1 TACLR = 1'b1;
        @(posedge MCLK); #1 TACLR = 1'b0;
    endtask

    task automatic load(input logic [15:0] v);
        @(posedge MCLK); #1 TAR_wr = 1'b1; TAR_wdata = v;
        @(posedge MCLK); #1 TAR_wr = 1'b0;
    endtask

    // Scoreboard monitor: each TimerTick retires one expected TAR update.
    initial begin
        exp_t e;
        forever begin
            @(negedge MCLK);
            if (sb_en && TimerTick) begin
                @(negedge MCLK);
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected_tick: got tick with TAR=%0h, none expected", TAR);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_tar", {16'd0, TAR}, {16'd0, e.tar});
                    check("sb_taifg", {31'd0, TAIFGset}, {31'd0, e.flag});
                    check("sb_countdown", {31'd0, CountDown}, {31'd0, e.cd});
                end
            end
        end
    end

    // TAIFGset must only follow a TimerTick cycle; also count ticks.
    always @(negedge MCLK) begin
        if (TAIFGset && !tick_prev) spur++;
        if (TimerTick) tick_cnt++;
        tick_prev = TimerTick;
    end

    localparam logic [15:0] UP_TAR [10] = '{1, 2, 3, 0, 1, 2, 3, 0, 0, 0};
    localparam logic        UP_FLG [10] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    localparam logic [15:0] UD_TAR [7]  = '{1, 2, 3, 2, 1, 0, 1};
    localparam logic        UD_FLG [7]  = '{0, 0, 0, 0, 0, 1, 0};
    localparam logic        UD_CD  [7]  = '{0, 0, 0, 1, 1, 0, 0};

    initial begin
        int base;
        repeat (3) @(posedge MCLK);
        #1;
        check("rst_tar", {16'd0, TAR}, 32'd0);
        check("rst_tick", {31'd0, TimerTick}, 32'd0);
        check("rst_taifg", {31'd0, TAIFGset}, 32'd0);
        check("rst_countdown", {31'd0, CountDown}, 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge MCLK);

        // Up mode, CCR0=3, then CCR0=0 once back at zero.
        MC = 2'b01; CCR0 = 16'd3; sb_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 8) CCR0 = 16'd0;
            push(UP_TAR[i], UP_FLG[i], 1'b0);
            pulse();
        end
        check("up_drain", sb_q.size(), 32'd0);

        // Up/down mode, CCR0=3.
        clear_pulse();
        MC = 2'b11; CCR0 = 16'd3;
        for (int i = 0; i < 7; i++) begin
            push(UD_TAR[i], UD_FLG[i], UD_CD[i]);
            pulse();
        end
        check("updown_drain", sb_q.size(), 32'd0);

        // Continuous mode across the 16-bit wrap.
        MC = 2'b10;
        load(16'hFFFE);
        #1 check("cont_load", {16'd0, TAR}, 32'h0000FFFE);
        push(16'hFFFF, 1'b0, 1'b0); pulse();
        push(16'h0000, 1'b1, 1'b0); pulse();
        push(16'h0001, 1'b0, 1'b0); pulse();
        check("cont_drain", sb_q.size(), 32'd0);
        sb_en = 1'b0;

        // Divide by 2^2 * (2+1) = 12 in continuous mode.
        clear_pulse();
        ID = 2'b10; IDEX = 3'b010;
        base = tick_cnt;
        for (int i = 0; i < 11; i++) pulse();
        check("div12_early", tick_cnt - base, 32'd0);
        pulse();
        check("div12_first", tick_cnt - base, 32'd1);
        for (int i = 0; i < 12; i++) pulse();
        check("div12_second", tick_cnt - base, 32'd2);
        check("div12_tar", {16'd0, TAR}, 32'd2);

        // TACLR mid-count with a concurrent TAR_wr; /2 divider.
        clear_pulse();
        MC = 2'b01; CCR0 = 16'd5; ID = 2'b01; IDEX = 3'b000;
        for (int i = 0; i < 9; i++) pulse();
        check("clr_pre_tar", {16'd0, TAR}, 32'd4);
        @(posedge MCLK); #1 TACLR = 1'b1; TAR_wr = 1'b1; TAR_wdata = 16'h00AA;
        @(posedge MCLK); #1 TACLR = 1'b0; TAR_wr = 1'b0;
        check("clr_tar", {16'd0, TAR}, 32'd0);
        check("clr_taifg", {31'd0, TAIFGset}, 32'd0);
        pulse();
        check("clr_div_restart", {16'd0, TAR}, 32'd0);
        pulse();
        check("clr_div_full", {16'd0, TAR}, 32'd1);

        // Asynchronous reset mid-cycle.
        MC = 2'b00;
        load(16'h1234);
        #1 check("arst_pre", {16'd0, TAR}, 32'h00001234);
        @(posedge MCLK); #2 reset = 1'b0;
        #1;
        check("arst_tar", {16'd0, TAR}, 32'd0);
        check("arst_tick", {31'd0, TimerTick}, 32'd0);
        check("arst_taifg", {31'd0, TAIFGset}, 32'd0);
        @(posedge MCLK); #1 reset = 1'b1;

        check("spurious_taifg", spur, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
